reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port raddr_a  input  ADDR_W  read port A address.
REQ-006 SHALL provide port raddr_b  input  ADDR_W  read port B address.
REQ-007 SHALL provide port we  input  1  write enable.
REQ-008 SHALL provide port waddr  input  ADDR_W  write address.
REQ-009 SHALL provide port wdata  input  DATA_W  write data.
REQ-010 SHALL provide port rdata_a  output  DATA_W  read port A data, combinational from raddr_a.
REQ-011 SHALL provide port rdata_b  output  DATA_W  read port B data, combinational from raddr_b.
REQ-012 SHALL provide port ready  output  1  high when clear sequence complete and file usable.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 SHALL hold a clear counter clr_cnt of ADDR_W bits.
REQ-015 In CLEAR with reset low, each cycle SHALL write zero to entry clr_cnt and increment clr_cnt.
REQ-016 CLEAR SHALL transition to RUN on the cycle entry DEPTH-1 is cleared; RUN entered after exactly DEPTH-1 clear cycles (entry 0 is not stored).
REQ-017 RUN SHALL persist until reset; no other transition exists.
REQ-018 ready SHALL be 1 iff state is RUN.
REQ-019 Entry 0 SHALL read as zero on both ports at all times; writes to address 0 SHALL be discarded.
REQ-020 In RUN, we=1 with waddr!=0 SHALL store wdata to entry waddr at the rising edge; visible on read ports the following cycle.
REQ-021 In CLEAR, we SHALL be ignored; no user write modifies storage.
REQ-022 In CLEAR, rdata_a and rdata_b SHALL be forced to zero regardless of address.
REQ-023 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-024 Storage SHALL NOT be bulk-cleared in one cycle; clearing occurs only via the sequential CLEAR walk.

Reset
REQ-025 reset high at a rising edge SHALL set state to CLEAR and clr_cnt to 1.
REQ-026 While reset remains high, no entry SHALL be cleared or written and clr_cnt SHALL stay 1.
REQ-027 During and after reset until RUN: ready=0, rdata_a=0, rdata_b=0.
REQ-028 reset asserted mid-CLEAR or in RUN SHALL restart the full clear sequence from entry 1.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined: in RUN, if we=1, waddr!=0 and raddr_x==waddr, rdata_x SHALL equal wdata in the same cycle.
REQ-031 Without REGFILE_BYPASS_EN: rdata_x SHALL return the stored (pre-write) value in the write cycle.
REQ-032 Macro SHALL NOT alter FSM, ready timing, or reset behaviour.

Verification (DATA_W=32, ADDR_W=5)
REQ-033 reset high 1 cycle then low -> ready=0 for 31 cycles, ready=1 on cycle 32; all 32 addresses read 0x00000000.
REQ-034 RUN, write 0xDEADBEEF to r5, then raddr_a=5, raddr_b=5 -> both ports 0xDEADBEEF next cycle.
REQ-035 RUN, write 0x12345678 to r0 -> rdata_a at address 0 stays 0x00000000.
REQ-036 RUN, we=1 waddr=7 wdata=0xCAFEF00D raddr_a=7, r7 holding 0x11111111 -> same-cycle rdata_a=0xCAFEF00D with REGFILE_BYPASS_EN, 0x11111111 without.
REQ-037 Reset, wait 10 cycles, write 0xA5A5A5A5 to r3 (ignored), reassert reset 1 cycle -> ready rises 31 cycles after second release; r3 reads 0x00000000.
REQ-038 RUN with r9=0x55AA55AA, assert reset 1 cycle -> ready=0 immediately after edge; after ready returns, r9 reads 0x00000000.

Source files
------------

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with entry 0 hard-wired to zero and a sequential
// clear walk after reset. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                ready_q;
    logic [DATA_W-1:0]   mem_q [1:DEPTH-1];

    logic                rd_en_s;
    logic                user_we_s;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_d;
    logic [DATA_W-1:0]   mem_wdata_d;

    // Reads and user writes are only live in RUN and outside reset.
    assign rd_en_s   = (state_q == ST_RUN) && !reset;
    assign user_we_s = rd_en_s && we && (waddr != ADDR_ZERO);
    assign ready     = ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= ADDR_ONE;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_ONE;
                    if (clr_cnt_q == ADDR_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_CLEAR;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= ADDR_ONE;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_cnt_q;
        mem_wdata_d = DATA_ZERO;
        case (state_q)
            ST_CLEAR: begin
                if (!reset) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = clr_cnt_q;
                    mem_wdata_d = DATA_ZERO;
                end else begin
                    mem_we_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (user_we_s) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = waddr;
                    mem_wdata_d = wdata;
                end else begin
                    mem_we_d    = 1'b0;
                end
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Storage has no reset; it is zeroed only by the clear walk.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_comb begin
        rdata_a = DATA_ZERO;
        if (rd_en_s && (raddr_a != ADDR_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
            if (user_we_s && (raddr_a == waddr)) begin
                rdata_a = wdata;
            end else begin
                rdata_a = mem_q[raddr_a];
            end
`else
            rdata_a = mem_q[raddr_a];
`endif
        end else begin
            rdata_a = DATA_ZERO;
        end
    end

    always_comb begin
        rdata_b = DATA_ZERO;
        if (rd_en_s && (raddr_b != ADDR_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
            if (user_we_s && (raddr_b == waddr)) begin
                rdata_b = wdata;
            end else begin
                rdata_b = mem_q[raddr_b];
            end
`else
            rdata_b = mem_q[raddr_b];
`endif
        end else begin
            rdata_b = DATA_ZERO;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (DATA_W=32, ADDR_W=5): table-driven vectors
// through a scoreboard queue plus hand-written reset/clear sequences.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[12];

    reg_file_mp #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One vector per cycle: drive after the edge, compare from the scoreboard at negedge.
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        we      = v.we;
        waddr   = v.waddr;
        wdata   = v.wdata;
        raddr_a = v.ra;
        raddr_b = v.rb;
        e.name = name;
        e.ea   = v.ea;
        e.eb   = v.eb;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_a"}, rdata_a, e.ea);
            chk({e.name, "_b"}, rdata_b, e.eb);
        end
    endtask

    // Called just after reset release; counts not-ready cycles up to a bound.
    task automatic wait_ready(input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (ready !== 1'b1 && c < 100) begin
            chk({name, "_clr_rd_a"}, rdata_a, 32'h0000_0000);
            chk({name, "_clr_rd_b"}, rdata_b, 32'h0000_0000);
            c++;
            @(negedge clk);
        end
        chk({name, "_clr_cycles"}, c, 32'd31);
        chk({name, "_ready"}, {31'd0, ready}, 32'd1);
        we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        reset   = 1'b1;
        we      = 1'b0;
        waddr   = 5'd0;
        wdata   = 32'h0;
        raddr_a = 5'd9;
        raddr_b = 5'd5;

        tbl[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd5,  32'h0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0, 32'h0};
        tbl[4]  = '{1'b1, 5'd7,  32'h1111_1111, 5'd7,  5'd31, BYP ? 32'h1111_1111 : 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 5'd7,  32'hCAFE_F00D, 5'd7,  5'd5,  BYP ? 32'hCAFE_F00D : 32'h1111_1111, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[7]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd1,  BYP ? 32'hFFFF_FFFF : 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 5'd1,  32'h0000_0001, 5'd31, 5'd1,  32'hFFFF_FFFF, BYP ? 32'h0000_0001 : 32'h0};
        tbl[9]  = '{1'b1, 5'd9,  32'h55AA_55AA, 5'd1,  5'd9,  32'h0000_0001, BYP ? 32'h55AA_55AA : 32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         5'd9,  5'd31, 32'h55AA_55AA, 32'hFFFF_FFFF};
        tbl[11] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd1,  32'hDEAD_BEEF, 32'h0000_0001};

        // Held reset: ready and reads stay zero.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd_a", rdata_a, 32'h0);
        chk("rst_rd_b", rdata_b, 32'h0);

        // Bring-up with a user write attempted throughout the clear walk.
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b1;
        waddr = 5'd2;
        wdata = 32'hA5A5_A5A5;
        wait_ready("bringup");

        for (int a = 0; a < 32; a++) begin
            v = '{1'b0, 5'd0, 32'h0, a[4:0], 5'(31 - a), 32'h0, 32'h0};
            apply($sformatf("zero_r%0d", a), v);
        end

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset from RUN restarts the clear walk and wipes r9/r5.
        we = 1'b0;
        raddr_a = 5'd9;
        raddr_b = 5'd5;
        pulse_reset();
        chk("run_rst_ready", {31'd0, ready}, 32'd0);
        wait_ready("run_rst");
        apply("run_rst_r9", '{1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h0, 32'h0});

        // Reset, write during clear, then reset again mid-walk.
        pulse_reset();
        repeat (10) @(posedge clk);
        #1;
        we      = 1'b1;
        waddr   = 5'd3;
        wdata   = 32'hA5A5_A5A5;
        raddr_a = 5'd3;
        raddr_b = 5'd3;
        @(negedge clk);
        chk("clr_wr_rd_a", rdata_a, 32'h0);
        chk("clr_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        we    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready("mid_clr_rst");
        apply("mid_clr_r3", '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'h0, 32'h0});

        // Post-restart writes still work on both ports.
        apply("post_wr", '{1'b1, 5'd12, 32'h0BAD_F00D, 5'd12, 5'd0, BYP ? 32'h0BAD_F00D : 32'h0, 32'h0});
        apply("post_rd", '{1'b0, 5'd0, 32'h0, 5'd0, 5'd12, 32'h0, 32'h0BAD_F00D});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
